// File: rtl/button_reader.sv
// Synchronised, debounced button bank with change events and press count.
// Optional long-press pulses are built only when LONGPRESS_EN is defined.
module button_reader #(
  parameter int WIDTH       = 8,
  parameter int DEBOUNCE    = 1024,
  parameter int CNT_WIDTH   = 8,
  parameter int LONG_CYCLES = 65536
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     BTN,
  output logic [WIDTH-1:0]     STATE,
  output logic                 EVT_VALID,
  input  logic                 EVT_READY,
  output logic [WIDTH-1:0]     EVT_DATA,
  output logic [WIDTH-1:0]     EVT_RISE,
  output logic                 OVF,
  output logic [CNT_WIDTH-1:0] PRESS_COUNT,
  output logic [WIDTH-1:0]     LONG
);

  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  if (DEBOUNCE < 2 || LONG_CYCLES < 2) begin : g_bad_param
    $error("button_reader: DEBOUNCE and LONG_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0]     r_sync1;
  logic [WIDTH-1:0]     r_sync2;
  logic [WIDTH-1:0]     r_state;
  logic [DW-1:0]        r_cnt [WIDTH];
  logic                 r_evt_valid;
  logic [WIDTH-1:0]     r_evt_data;
  logic [WIDTH-1:0]     r_evt_rise;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_press;

  logic [WIDTH-1:0]     w_state_nxt;
  logic [DW-1:0]        w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0]     w_chg;
  logic [WIDTH-1:0]     w_rise;
  logic                 w_take;
  logic                 w_drop;

  // Any cycle of agreement with the stable value restarts the count.
  always_comb begin
    w_state_nxt = r_state;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_state[i]) begin
        if (r_cnt[i] == DB_LAST)
          w_state_nxt[i] = r_sync2[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_chg  = r_state ^ w_state_nxt;
    w_rise = w_chg & w_state_nxt;
    w_take = (|w_chg) && (!r_evt_valid || EVT_READY);
    w_drop = (|w_chg) && r_evt_valid && !EVT_READY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= '0;
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // A change arriving while the consumer stalls is lost and flagged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_evt_rise  <= '0;
      r_ovf       <= 1'b0;
      r_press     <= '0;
    end else begin
      if (w_take) begin
        r_evt_valid <= 1'b1;
        r_evt_data  <= w_state_nxt;
        r_evt_rise  <= w_rise;
        if (|w_rise)
          r_press <= r_press + 1'b1;
      end else if (r_evt_valid && EVT_READY) begin
        r_evt_valid <= 1'b0;
      end
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

`ifdef LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LG_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LG_PRE = LW'(LONG_CYCLES - 2);

  logic [LW-1:0]    r_lcnt [WIDTH];
  logic [WIDTH-1:0] r_long;

  // Saturation keeps the pulse to one per press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_long <= '0;
      for (int i = 0; i < WIDTH; i++)
        r_lcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_long[i] <= 1'b0;
        if (!r_state[i]) begin
          r_lcnt[i] <= '0;
        end else if (r_lcnt[i] != LG_MAX) begin
          r_lcnt[i] <= r_lcnt[i] + 1'b1;
          if (r_lcnt[i] == LG_PRE)
            r_long[i] <= 1'b1;
        end
      end
    end
  end

  assign LONG = r_long;
`else
  assign LONG = '0;
`endif

  assign STATE       = r_state;
  assign EVT_VALID   = r_evt_valid;
  assign EVT_DATA    = r_evt_data;
  assign EVT_RISE    = r_evt_rise;
  assign OVF         = r_ovf;
  assign PRESS_COUNT = r_press;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: queued expected events,
// monitor pops on each accepted handshake.
module tb_button_reader;

  localparam int W  = 8;
  localparam int DB = 16;
  localparam int CW = 8;
  localparam int LC = 100;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  BTN;
  logic [W-1:0]  STATE;
  logic          EVT_VALID;
  logic          EVT_READY;
  logic [W-1:0]  EVT_DATA;
  logic [W-1:0]  EVT_RISE;
  logic          OVF;
  logic [CW-1:0] PRESS_COUNT;
  logic [W-1:0]  LONG;

  typedef struct {
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  button_reader #(
    .WIDTH(W), .DEBOUNCE(DB), .CNT_WIDTH(CW), .LONG_CYCLES(LC)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .STATE(STATE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .EVT_DATA(EVT_DATA), .EVT_RISE(EVT_RISE), .OVF(OVF),
    .PRESS_COUNT(PRESS_COUNT), .LONG(LONG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] r,
                      input logic [7:0] pc);
    exp_t e;
    e.d = d; e.r = r; e.pc = pc;
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST && EVT_VALID && EVT_READY) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got %h want none", EVT_DATA);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_data", 32'(EVT_DATA), 32'(e.d));
        chk("evt_rise", 32'(EVT_RISE), 32'(e.r));
        chk("evt_count", 32'(PRESS_COUNT), 32'(e.pc));
      end
    end
  end

  int nlong;
  int at_long;
  logic [7:0] pc;

  initial begin
    RST = 1'b1;
    BTN = '0;
    EVT_READY = 1'b1;
    step(3);
    chk("rst_state", 32'(STATE), 0);
    chk("rst_valid", 32'(EVT_VALID), 0);
    chk("rst_ovf", 32'(OVF), 0);
    chk("rst_count", 32'(PRESS_COUNT), 0);
    chk("rst_long", 32'(LONG), 0);
    RST = 1'b0;
    step(2);

    // clean press of bit 0, 18-cycle latency
    BTN = 8'h01;
    push(8'h01, 8'h01, 8'd1);
    step(17);
    chk("lat_early", 32'(STATE), 0);
    step(1);
    chk("lat_exact", 32'(STATE), 32'h01);
    chk("lat_valid", 32'(EVT_VALID), 1);
    step(1);
    chk("valid_drop", 32'(EVT_VALID), 0);
    step(5);

    // glitchy bit 3: 15 high, 1 low, then high
    BTN = 8'h09;
    step(15);
    BTN = 8'h01;
    step(1);
    BTN = 8'h09;
    push(8'h09, 8'h08, 8'd2);
    step(3);
    chk("glitch_hold", 32'(STATE), 32'h01);
    step(14);
    chk("glitch_early", 32'(STATE), 32'h01);
    step(1);
    chk("glitch_rise", 32'(STATE), 32'h09);
    step(5);
    BTN = 8'h00;
    push(8'h00, 8'h00, 8'd2);
    step(25);

    // stalled consumer: second change dropped
    EVT_READY = 1'b0;
    BTN = 8'h01;
    push(8'h01, 8'h01, 8'd3);
    step(40);
    BTN = 8'h03;
    step(20);
    chk("ovf_valid", 32'(EVT_VALID), 1);
    chk("ovf_data", 32'(EVT_DATA), 32'h01);
    chk("ovf_flag", 32'(OVF), 1);
    chk("ovf_count", 32'(PRESS_COUNT), 3);
    EVT_READY = 1'b1;
    step(1);
    chk("ovf_accept", 32'(EVT_VALID), 0);
    BTN = 8'h00;
    push(8'h00, 8'h00, 8'd3);
    step(25);

    // simultaneous bits form one event
    BTN = 8'h81;
    push(8'h81, 8'h81, 8'd4);
    step(25);
    BTN = 8'h00;
    push(8'h00, 8'h00, 8'd4);
    step(25);
    chk("multi_count", 32'(PRESS_COUNT), 4);
    chk("ovf_sticky", 32'(OVF), 1);

    // reset, then 256 presses wrap the counter
    RST = 1'b1;
    step(2);
    chk("rst2_ovf", 32'(OVF), 0);
    RST = 1'b0;
    pc = 8'd0;
    for (int k = 0; k < 256; k++) begin
      pc = pc + 8'd1;
      BTN = 8'h01;
      push(8'h01, 8'h01, pc);
      step(20);
      BTN = 8'h00;
      push(8'h00, 8'h00, pc);
      step(20);
    end
    chk("wrap_count", 32'(PRESS_COUNT), 0);

    // reset with an event pending and a debounce in flight
    EVT_READY = 1'b0;
    BTN = 8'h10;
    step(25);
    BTN = 8'h30;
    step(10);
    RST = 1'b1;
    BTN = 8'h00;
    q.delete();
    step(2);
    chk("rst3_state", 32'(STATE), 0);
    chk("rst3_valid", 32'(EVT_VALID), 0);
    chk("rst3_data", 32'(EVT_DATA), 0);
    chk("rst3_rise", 32'(EVT_RISE), 0);
    chk("rst3_ovf", 32'(OVF), 0);
    chk("rst3_count", 32'(PRESS_COUNT), 0);
    RST = 1'b0;
    EVT_READY = 1'b1;
    step(40);
    chk("rst3_quiet", 32'(EVT_VALID), 0);
    chk("rst3_stable", 32'(STATE), 0);

    // long press on bit 2
    BTN = 8'h04;
    push(8'h04, 8'h04, 8'd1);
    step(18);
    chk("long_rise", 32'(STATE), 32'h04);
    nlong = 0;
    at_long = -1;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      if (LONG != '0) begin
        nlong++;
        at_long = k;
      end
    end
`ifdef LONGPRESS_EN
    chk("long_pulses", 32'(nlong), 1);
    chk("long_when", 32'(at_long), 99);
`else
    chk("long_pulses", 32'(nlong), 0);
    chk("long_when", 32'(at_long), 32'hffffffff);
`endif
    BTN = 8'h00;
    push(8'h00, 8'h00, 8'd1);

    for (int k = 0; k < 60 && q.size() != 0; k++)
      step(1);
    chk("queue_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
Input-side counterpart to the LED counter/driver: reads WIDTH asynchronous push-buttons or switches, synchronises and debounces each bit, and publishes the stable vector. Each debounced change is reported as an event over a valid/ready handshake, and a wrapping press counter is kept. Sits between board I/O pins and control logic that consumes user input.

Parameters:
WIDTH, 8, number of button/switch inputs
DEBOUNCE, 1024, consecutive cycles an input must differ from the stable value before the stable value changes (>=2)
CNT_WIDTH, 8, width of press counter
LONG_CYCLES, 65536, hold time for long-press pulse (used only with LONGPRESS_EN)

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
BTN  input  WIDTH  raw asynchronous button levels, 1 = pressed
STATE  output  WIDTH  debounced stable levels (registered)
EVT_VALID  output  1  change event pending
EVT_READY  input  1  consumer accepts event
EVT_DATA  output  WIDTH  STATE snapshot at event
EVT_RISE  output  WIDTH  bits that went 0->1 in this event
OVF  output  1  sticky: an event was dropped
PRESS_COUNT  output  CNT_WIDTH  count of events containing >=1 rising bit, wraps
LONG  output  WIDTH  one-cycle long-press pulse per bit (0 without LONGPRESS_EN)

Behaviour:
- Reset: RST, synchronous, active-high; clock CLK. While RST is high: sync flops, debounce counters, STATE, EVT_VALID, EVT_DATA, EVT_RISE, OVF, PRESS_COUNT, LONG and long-press counters all cleared to 0. Reset mid-debounce or with an event pending discards all progress; nothing is reported after reset is released.
- Sync: per bit, 2-flop synchroniser; s = second flop.
- Debounce per bit i: counter cnt_i, width clog2(DEBOUNCE). If s[i]==STATE[i]: cnt_i<=0. Else if cnt_i==DEBOUNCE-1: STATE[i]<=s[i], cnt_i<=0. Else cnt_i<=cnt_i+1. A single-cycle agreement resets progress (glitch rejection).
- Latency: a clean BTN edge appears on STATE exactly 2+DEBOUNCE cycles later.
- chg = bits of STATE toggling on this edge; rise = chg & next STATE. Multiple bits toggling on the same edge form one event.
- Event register, per edge:
  - chg!=0 and (!EVT_VALID or EVT_READY): EVT_VALID<=1, EVT_DATA<=next STATE, EVT_RISE<=rise; if rise!=0, PRESS_COUNT<=PRESS_COUNT+1 (mod 2^CNT_WIDTH).
  - chg!=0 and EVT_VALID and !EVT_READY: event dropped, OVF<=1, EVT_* unchanged, PRESS_COUNT unchanged.
  - chg==0 and EVT_VALID and EVT_READY: EVT_VALID<=0, EVT_DATA/EVT_RISE hold.
- EVT_DATA/EVT_RISE stable while EVT_VALID=1 and not accepted. EVT_READY ignored when EVT_VALID=0.
- Back-to-back: accept and new change on the same edge -> EVT_VALID stays 1 with new data, no OVF.
- OVF cleared only by RST.

Optional Feature:
Macro LONGPRESS_EN. Defined: per-bit counter of width clog2(LONG_CYCLES+1) clears when STATE[i]==0, increments while STATE[i]==1 and saturates at LONG_CYCLES; LONG[i] pulses high for exactly one cycle on the edge where the counter reaches LONG_CYCLES-1, measured from the STATE rise (one pulse per press; re-press required for another). Not defined: no long-press counters instantiated, LONG driven constant 0.

Test Plan:
- DEBOUNCE=16, WIDTH=8: BTN[0] 0->1 clean, EVT_READY=1 -> STATE[0]=1 exactly 18 cycles later; EVT_VALID 1 for one cycle, EVT_DATA=8'h01, EVT_RISE=8'h01, PRESS_COUNT=1.
- BTN[3] high 15 cycles, low 1, high 20 -> STATE[3] rises 18 cycles after the last rise, single event, never earlier.
- EVT_READY=0, press bit 0 then bit 1 (spaced 40 cycles) -> EVT_DATA stays 8'h01, OVF=1, PRESS_COUNT=1; raise EVT_READY -> EVT_VALID falls next edge.
- BTN 8'h00->8'h81 simultaneously -> one event, EVT_DATA=8'h81, EVT_RISE=8'h81, PRESS_COUNT +1; release -> event EVT_DATA=8'h00, EVT_RISE=0, count unchanged.
- CNT_WIDTH=8, 256 presses with READY=1 -> PRESS_COUNT wraps to 0; RST asserted mid-debounce -> all outputs 0, no event after release.
- LONGPRESS_EN, LONG_CYCLES=100: hold bit 2 -> LONG[2] single pulse 99 cycles after STATE[2] rise; without macro LONG stays 0.
